imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage_if.sv | 59 +++++
 rtl/imm_decode_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode_stage_if
//  Description : Handshake bundle for imm_decode_stage. The upstream side
//                carries a raw instruction and its PC. The downstream side
//                carries the decoded immediate, its format code, the illegal
//                flag and the PC that goes with it.
//                master : the agent that drives instructions in and takes
//                         decoded entries out
//                slave  : the decode stage itself
//  Ports       : in_valid/in_ready/in_inst/in_pc      (upstream handshake)
//                out_valid/out_ready/out_imm/out_fmt/
//                out_illegal/out_pc                   (downstream handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_decode_stage_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid,
        output in_inst,
        output in_pc,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_fmt,
        input  out_illegal,
        input  out_pc
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_pc,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_fmt,
        output out_illegal,
        output out_pc
    );

endinterface
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode_stage
//  Description : RISC-V immediate decode stage. It extracts and
//                sign-extends the immediate of each instruction and
//                classifies its format. Results pass through a
//                two-entry elastic buffer: an output register plus one skid
//                register. This gives one-cycle latency and full throughput.
//  Ports       : clk    - clock, all state changes on the rising edge
//                rst_n  - synchronous active-low reset
//                flush  - synchronous discard of every held entry
//                bus    - imm_decode_stage_if.slave (in_* / out_* handshake)
//  Parameters  : XLEN   - immediate / PC width, 32 or 64
//                RV64_W - 1 enables OP-IMM-32 / OP-32 decode when XLEN=64
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN   = 32,
    parameter bit RV64_W = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          flush,
    imm_decode_stage_if.slave  bus
);

    // ------------------------------------------------------------------
    // Format codes
    // ------------------------------------------------------------------
    localparam logic [2:0] c_fmt_r     = 3'd0;
    localparam logic [2:0] c_fmt_i     = 3'd1;
    localparam logic [2:0] c_fmt_s     = 3'd2;
    localparam logic [2:0] c_fmt_b     = 3'd3;
    localparam logic [2:0] c_fmt_u     = 3'd4;
    localparam logic [2:0] c_fmt_j     = 3'd5;
    localparam logic [2:0] c_fmt_shamt = 3'd6;
    localparam logic [2:0] c_fmt_none  = 3'd7;

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_imm32  = 7'b0011011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_op32   = 7'b0111011;

    // The W-form opcodes exist only on a 64-bit datapath with RV64_W set.
    localparam bit c_xlen64 = (XLEN == 64);
    localparam bit c_rv64w  = RV64_W && c_xlen64;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_is_shift;
    logic [11:0]     w_imm_i;
    logic [11:0]     w_imm_s;
    logic [12:0]     w_imm_b;
    logic [31:0]     w_imm_u;
    logic [20:0]     w_imm_j;
    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_fmt;
    logic            w_dec_illegal;
    logic            w_narrow;

    assign w_inst     = bus.in_inst;
    assign w_opcode   = w_inst[6:0];
    assign w_funct3   = w_inst[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    assign w_imm_i = w_inst[31:20];
    assign w_imm_s = {w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    always_comb begin
        w_dec_imm     = '0;
        w_dec_fmt     = c_fmt_none;
        w_dec_illegal = 1'b1;
        // A narrow shift has a 5-bit shamt. This covers every RV32 shift
        // and the W-form shifts, where inst[25] must be zero.
        w_narrow      = !c_xlen64;

        case (w_opcode)
            c_op_load, c_op_jalr: begin
                w_dec_imm     = XLEN'($signed(w_imm_i));
                w_dec_fmt     = c_fmt_i;
                w_dec_illegal = 1'b0;
            end
            c_op_imm, c_op_imm32: begin
                if ((w_opcode == c_op_imm32) && !c_rv64w) begin
                    w_dec_fmt     = c_fmt_none;
                    w_dec_illegal = 1'b1;
                end else if (w_is_shift) begin
                    w_narrow  = !c_xlen64 || (w_opcode == c_op_imm32);
                    w_dec_fmt = c_fmt_shamt;
                    if (w_narrow && w_inst[25]) begin
                        w_dec_imm     = '0;
                        w_dec_illegal = 1'b1;
                    end else if (w_narrow) begin
                        w_dec_imm     = XLEN'(w_inst[24:20]);
                        w_dec_illegal = 1'b0;
                    end else begin
                        w_dec_imm     = XLEN'(w_inst[25:20]);
                        w_dec_illegal = 1'b0;
                    end
                end else begin
                    w_dec_imm     = XLEN'($signed(w_imm_i));
                    w_dec_fmt     = c_fmt_i;
                    w_dec_illegal = 1'b0;
                end
            end
            c_op_store: begin
                w_dec_imm     = XLEN'($signed(w_imm_s));
                w_dec_fmt     = c_fmt_s;
                w_dec_illegal = 1'b0;
            end
            c_op_branch: begin
                w_dec_imm     = XLEN'($signed(w_imm_b));
                w_dec_fmt     = c_fmt_b;
                w_dec_illegal = 1'b0;
            end
            c_op_lui, c_op_auipc: begin
                w_dec_imm     = XLEN'($signed(w_imm_u));
                w_dec_fmt     = c_fmt_u;
                w_dec_illegal = 1'b0;
            end
            c_op_jal: begin
                w_dec_imm     = XLEN'($signed(w_imm_j));
                w_dec_fmt     = c_fmt_j;
                w_dec_illegal = 1'b0;
            end
            c_op_op: begin
                w_dec_fmt     = c_fmt_r;
                w_dec_illegal = 1'b0;
            end
            c_op_op32: begin
                if (c_rv64w) begin
                    w_dec_fmt     = c_fmt_r;
                    w_dec_illegal = 1'b0;
                end
            end
            default: begin
                w_dec_fmt     = c_fmt_none;
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Elastic buffer: output register + skid register
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic [2:0]      r_out_fmt;
    logic            r_out_illegal;
    logic [XLEN-1:0] r_out_pc;

    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_fmt;
    logic            r_skid_illegal;
    logic [XLEN-1:0] r_skid_pc;

    logic            w_accept;
    logic            w_out_free;

    // The skid slot absorbs the single entry that can arrive while the
    // output is stalled. Readiness therefore depends only on registered
    // state, and no combinational path runs from out_ready to in_ready.
    assign bus.in_ready = !r_skid_valid;
    assign w_accept     = bus.in_valid && !r_skid_valid;
    assign w_out_free   = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_fmt      <= '0;
            r_out_illegal  <= 1'b0;
            r_out_pc       <= '0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_fmt     <= '0;
            r_skid_illegal <= 1'b0;
            r_skid_pc      <= '0;
        end else if (flush) begin
            // Only the valid bits are dropped. The data fields keep their
            // last values, so the outputs stay free of X and do not toggle.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // in_ready is low here, so no new entry can arrive in the
                // same cycle. The older skid entry moves up first.
                r_out_valid    <= 1'b1;
                r_out_imm      <= r_skid_imm;
                r_out_fmt      <= r_skid_fmt;
                r_out_illegal  <= r_skid_illegal;
                r_out_pc       <= r_skid_pc;
                r_skid_valid   <= 1'b0;
            end else if (w_accept) begin
                r_out_valid    <= 1'b1;
                r_out_imm      <= w_dec_imm;
                r_out_fmt      <= w_dec_fmt;
                r_out_illegal  <= w_dec_illegal;
                r_out_pc       <= bus.in_pc;
            end else begin
                r_out_valid    <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid   <= 1'b1;
            r_skid_imm     <= w_dec_imm;
            r_skid_fmt     <= w_dec_fmt;
            r_skid_illegal <= w_dec_illegal;
            r_skid_pc      <= bus.in_pc;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_fmt     = r_out_fmt;
    assign bus.out_illegal = r_out_illegal;
    assign bus.out_pc      = r_out_pc;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_decode_stage
//  Description : Directed self-checking bench for imm_decode_stage. It
//                drives one RV32 instance (RV64_W=0) and one RV64 instance
//                (RV64_W=1). Expected values are hand-computed from the
//                encoding of each instruction.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    imm_decode_stage #(.XLEN(32), .RV64_W(1'b0)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b32.slave)
    );

    imm_decode_stage #(.XLEN(64), .RV64_W(1'b1)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b64.slave)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t v32 [14];
    vec_t v64 [7];

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Hand-decoded vectors for the RV32 instance.
        v32[0]  = '{32'h0100006F, 64'h0000_0010, 3'd5, 1'b0}; // jal x0,16
        v32[1]  = '{32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 1'b0}; // beq -4
        v32[2]  = '{32'hFE000E63, 64'hFFFF_F7FC, 3'd3, 1'b0}; // inst[7]=0 -> imm[11]=0
        v32[3]  = '{32'h02109093, 64'h0000_0000, 3'd6, 1'b1}; // slli shamt[5]=1
        v32[4]  = '{32'h00509093, 64'h0000_0005, 3'd6, 1'b0}; // slli 5
        v32[5]  = '{32'h4020D093, 64'h0000_0002, 3'd6, 1'b0}; // srai 2
        v32[6]  = '{32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0}; // addi -1
        v32[7]  = '{32'hFE112C23, 64'hFFFF_FFF8, 3'd2, 1'b0}; // sw -8
        v32[8]  = '{32'h12345097, 64'h1234_5000, 3'd4, 1'b0}; // auipc
        v32[9]  = '{32'h002081B3, 64'h0000_0000, 3'd0, 1'b0}; // add
        v32[10] = '{32'h0010809B, 64'h0000_0000, 3'd7, 1'b1}; // OP-IMM-32 on RV32
        v32[11] = '{32'h0000903B, 64'h0000_0000, 3'd7, 1'b1}; // OP-32 on RV32
        v32[12] = '{32'h00000000, 64'h0000_0000, 3'd7, 1'b1}; // unknown opcode
        v32[13] = '{32'h00008067, 64'h0000_0000, 3'd1, 1'b0}; // jalr x0,0(x1)

        // Hand-decoded vectors for the RV64 instance.
        v64[0] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}; // lui
        v64[1] = '{32'h02109093, 64'h0000_0000_0000_0021, 3'd6, 1'b0}; // slli 33
        v64[2] = '{32'h02009093, 64'h0000_0000_0000_0020, 3'd6, 1'b0}; // slli 32
        v64[3] = '{32'h0010809B, 64'h0000_0000_0000_0001, 3'd1, 1'b0}; // addiw 1
        v64[4] = '{32'h0200909B, 64'h0000_0000_0000_0000, 3'd6, 1'b1}; // slliw shamt[5]=1
        v64[5] = '{32'h0000903B, 64'h0000_0000_0000_0000, 3'd0, 1'b0}; // OP-32
        v64[6] = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0}; // addi -1

        // ---------------- Reset ----------------
        rst_n = 1'b0;
        flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_pc = '0; b64.out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        chk("rst32_valid",   64'(b32.out_valid),   64'd0);
        chk("rst32_imm",     64'(b32.out_imm),     64'd0);
        chk("rst32_fmt",     64'(b32.out_fmt),     64'd0);
        chk("rst32_ill",     64'(b32.out_illegal), 64'd0);
        chk("rst32_pc",      64'(b32.out_pc),      64'd0);
        chk("rst32_inready", 64'(b32.in_ready),    64'd1);
        chk("rst64_valid",   64'(b64.out_valid),   64'd0);
        chk("rst64_imm",     64'(b64.out_imm),     64'd0);
        chk("rst64_inready", 64'(b64.in_ready),    64'd1);

        // ---------------- RV32 back-to-back decode ----------------
        for (int i = 0; i < 14; i++) begin
            b32.in_valid = 1'b1;
            b32.in_inst  = v32[i].inst;
            b32.in_pc    = 32'h1000 + 32'(i * 4);
            step();
            chk($sformatf("d32_%0d_valid", i), 64'(b32.out_valid),   64'd1);
            chk($sformatf("d32_%0d_imm",   i), 64'(b32.out_imm),     v32[i].imm);
            chk($sformatf("d32_%0d_fmt",   i), 64'(b32.out_fmt),     64'(v32[i].fmt));
            chk($sformatf("d32_%0d_ill",   i), 64'(b32.out_illegal), 64'(v32[i].ill));
            chk($sformatf("d32_%0d_pc",    i), 64'(b32.out_pc),      64'h1000 + 64'(i * 4));
            chk($sformatf("d32_%0d_rdy",   i), 64'(b32.in_ready),    64'd1);
        end
        b32.in_valid = 1'b0;
        step();
        chk("d32_drained", 64'(b32.out_valid), 64'd0);

        // ---------------- RV64 back-to-back decode ----------------
        for (int i = 0; i < 7; i++) begin
            b64.in_valid = 1'b1;
            b64.in_inst  = v64[i].inst;
            b64.in_pc    = 64'h8000_0000_0000_2000 + 64'(i * 4);
            step();
            chk($sformatf("d64_%0d_valid", i), 64'(b64.out_valid),   64'd1);
            chk($sformatf("d64_%0d_imm",   i), b64.out_imm,          v64[i].imm);
            chk($sformatf("d64_%0d_fmt",   i), 64'(b64.out_fmt),     64'(v64[i].fmt));
            chk($sformatf("d64_%0d_ill",   i), 64'(b64.out_illegal), 64'(v64[i].ill));
            chk($sformatf("d64_%0d_pc",    i), b64.out_pc,           64'h8000_0000_0000_2000 + 64'(i * 4));
        end
        b64.in_valid = 1'b0;
        step();
        chk("d64_drained", 64'(b64.out_valid), 64'd0);

        // ---------------- Skid: A,B,C under stall, then drain ----------------
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1; b32.in_inst = v32[0].inst; b32.in_pc = 32'h200; // A
        step();
        chk("skid_a_valid", 64'(b32.out_valid), 64'd1);
        chk("skid_a_pc",    64'(b32.out_pc),    64'h200);
        chk("skid_a_rdy",   64'(b32.in_ready),  64'd1);
        b32.in_inst = v32[6].inst; b32.in_pc = 32'h204;                       // B
        step();
        chk("skid_b_pc_hold",  64'(b32.out_pc),   64'h200);
        chk("skid_b_imm_hold", 64'(b32.out_imm),  64'h10);
        chk("skid_b_rdy",      64'(b32.in_ready), 64'd0);
        b32.in_inst = v32[7].inst; b32.in_pc = 32'h208;                       // C
        step();
        chk("skid_c_pc_hold",  64'(b32.out_pc),   64'h200);
        chk("skid_c_fmt_hold", 64'(b32.out_fmt),  64'd5);
        chk("skid_c_rdy",      64'(b32.in_ready), 64'd0);
        b32.out_ready = 1'b1;
        step();
        chk("drain_b_valid", 64'(b32.out_valid), 64'd1);
        chk("drain_b_pc",    64'(b32.out_pc),    64'h204);
        chk("drain_b_imm",   64'(b32.out_imm),   64'hFFFF_FFFF);
        chk("drain_b_rdy",   64'(b32.in_ready),  64'd1);
        step();
        chk("drain_c_valid", 64'(b32.out_valid), 64'd1);
        chk("drain_c_pc",    64'(b32.out_pc),    64'h208);
        chk("drain_c_imm",   64'(b32.out_imm),   64'hFFFF_FFF8);
        b32.in_valid = 1'b0;
        step();
        chk("drain_empty", 64'(b32.out_valid), 64'd0);

        // ---------------- Flush with both slots full ----------------
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1; b32.in_inst = v32[4].inst; b32.in_pc = 32'h300;
        step();
        b32.in_inst = v32[5].inst; b32.in_pc = 32'h304;
        step();
        chk("flush_pre_rdy", 64'(b32.in_ready), 64'd0);
        flush = 1'b1;
        b32.in_inst = v32[8].inst; b32.in_pc = 32'h308;
        step();
        flush = 1'b0;
        b32.in_valid = 1'b0;
        chk("flush_valid",   64'(b32.out_valid), 64'd0);
        chk("flush_rdy",     64'(b32.in_ready),  64'd1);
        chk("flush_pc_keep", 64'(b32.out_pc),    64'h300);
        b32.out_ready = 1'b1;
        step();
        chk("flush_no_ghost", 64'(b32.out_valid), 64'd0);
        step();
        chk("flush_no_ghost2", 64'(b32.out_valid), 64'd0);

        // ---------------- Reset mid-stream with both slots full ----------------
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1; b32.in_inst = v32[1].inst; b32.in_pc = 32'h400;
        step();
        b32.in_inst = v32[7].inst; b32.in_pc = 32'h404;
        step();
        chk("mrst_pre_rdy", 64'(b32.in_ready), 64'd0);
        b32.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_valid",   64'(b32.out_valid),   64'd0);
        chk("mrst_imm",     64'(b32.out_imm),     64'd0);
        chk("mrst_fmt",     64'(b32.out_fmt),     64'd0);
        chk("mrst_ill",     64'(b32.out_illegal), 64'd0);
        chk("mrst_pc",      64'(b32.out_pc),      64'd0);
        chk("mrst_rdy",     64'(b32.in_ready),    64'd1);
        b32.out_ready = 1'b1;
        step();
        chk("mrst_no_skid", 64'(b32.out_valid),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
